collision_monitor: RTL
======================

# collision_monitor

Pixel-stream collision detector between the sprite delegates and the game-state FSM. Each pixel cycle it checks whether a dino pixel and an obstacle pixel are both lit. It counts those overlaps per frame and confirms a hit over consecutive frames. On confirmation it issues a one-cycle `collide` pulse, which the game FSM uses to move from PLAY to DEAD.

## Interface
Parameters:
- `OVERLAP_MIN`, 4: minimum overlapping pixels in one frame for that frame to count as a hit frame.
- `FRAME_CONFIRM`, 2: consecutive hit frames required before `collide` fires (legal range 1..15).
- `CNT_W`, 12: width of the per-frame overlap counter.

Ports:
- `clk` input 1: pixel clock (25 MHz domain). All logic is on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `pix_valid` input 1: current x/y lies in the visible area.
- `frame_start` input 1: one-cycle pulse on the first pixel of a frame.
- `vga_x` input 10: current pixel column.
- `vga_y` input 10: current pixel row.
- `dino_pix` input 1: dino sprite covers the current pixel (grey or white).
- `obstacle_pix` input 1: obstacle sprite covers the current pixel.
- `game_state` input 2: 00 INIT, 01 PLAY, 10 DEAD.
- `collide` output 1: one-cycle confirmed-collision pulse.
- `overlap_count` output CNT_W: overlap total of the last completed frame.
- `hit_x` output 10: column of the first overlap pixel in the confirming frame.
- `hit_y` output 10: row of the first overlap pixel in the confirming frame.

## Operation
- FSM has three states: IDLE, ARMED, FIRED. Reset state is IDLE.
- IDLE → ARMED on a `frame_start` cycle with `game_state`==PLAY. Arming happens only at a frame boundary, so a partial frame is never counted.
- ARMED → FIRED when a frame evaluation brings `hit_frames` to FRAME_CONFIRM. `collide` pulses in that transition.
- ARMED → IDLE on any cycle where `game_state`≠PLAY. The counter and `hit_frames` clear.
- FIRED → IDLE when `game_state`≠PLAY. While in FIRED, no further `collide` is produced.
- Overlap event is `pix_valid & dino_pix & obstacle_pix`. It is counted only in ARMED.
- The counter saturates at 2^CNT_W−1 and never wraps.
- Frame evaluation happens on each `frame_start` cycle while ARMED:
  - `overlap_count` ← running count.
  - If the count ≥ OVERLAP_MIN, `hit_frames` increments, saturating at FRAME_CONFIRM. Otherwise it clears to 0.
  - The running count restarts.
- A `frame_start` cycle belongs to the new frame. The running count becomes 1 if that pixel overlaps, else 0.
- Hit position capture:
  - The first overlap in a frame records `vga_x`/`vga_y` into a pending register.
  - `hit_x`/`hit_y` load from the pending register only on the confirming evaluation. They hold until reset.

## Timing
- Reset values: `collide`=0, `overlap_count`=0, `hit_x`=0, `hit_y`=0, state=IDLE, `hit_frames`=0.
- `collide` is registered. It is high exactly for the cycle after the confirming `frame_start` edge, and never longer than one cycle.
- `overlap_count`, `hit_x` and `hit_y` update on the same edge that raises `collide`, and are stable while it is high.
- Detection latency is FRAME_CONFIRM frames plus 1 cycle after the last confirming frame's `frame_start`.
- If `game_state` leaves PLAY on the same edge as a confirming evaluation, the leave wins: no `collide`, next state IDLE.
- Reset asserted mid-frame clears everything immediately (asynchronous). Counting resumes only after the next arming `frame_start`.

## Configuration
- `COLLIDE_HITPOS_EN` defined: the pending and output hit-position registers are built, and `hit_x`/`hit_y` behave as in Operation.
- `COLLIDE_HITPOS_EN` undefined: no position registers exist, and `hit_x`/`hit_y` are tied to constant 0. All other behaviour is unchanged.

## Structure
- The shared package `trex_pkg` holds:
  - game-state encodings `GS_INIT`, `GS_PLAY`, `GS_DEAD`;
  - the monitor state encoding `CM_IDLE`, `CM_ARMED`, `CM_FIRED`;
  - the 10-bit coordinate width constant.
- One sub-module, `frame_overlap_counter`, is natural. It holds the saturating counter, the frame-boundary restart and the first-hit position capture. The FSM and confirmation logic stay in `collision_monitor`.

## Test plan
- Reset with `game_state`=PLAY and no overlaps for 3 frames → `collide` stays 0; `overlap_count`=0 after each frame.
- Defaults, 6 overlap pixels per frame for 2 frames, first overlap at (120,355) → `collide` high for one cycle after the 3rd `frame_start`; `overlap_count`=6; `hit_x`=120, `hit_y`=355.
- Frames with 6, 3, 6 overlaps → `hit_frames` resets on the 3-overlap frame; no `collide` until the next 6-overlap frame.
- `game_state` goes PLAY→DEAD on the confirming `frame_start` edge → no `collide`; state IDLE.
- Overlap on the `frame_start` pixel itself → that pixel is counted in the new frame: with 3 more overlaps in the frame, count is 4 and the frame qualifies.
- `rst` pulled low mid-frame during FIRED → all outputs 0 immediately; with `COLLIDE_HITPOS_EN` undefined, `hit_x`/`hit_y` are 0 in every scenario.

Source files
------------

// File: rtl/trex_pkg.sv
// -----------------------------------------------------------------------------
// trex_pkg
// Shared encodings for the T-Rex game blocks.
//   - COORD_W             : width of the VGA pixel coordinates
//   - game_state_e        : game FSM state as seen on the game_state bus
//   - cm_state_e          : collision monitor FSM state
// -----------------------------------------------------------------------------
package trex_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        GS_INIT = 2'b00,
        GS_PLAY = 2'b01,
        GS_DEAD = 2'b10
    } game_state_e;

    typedef enum logic [1:0] {
        CM_IDLE  = 2'b00,
        CM_ARMED = 2'b01,
        CM_FIRED = 2'b10
    } cm_state_e;

endpackage

// File: rtl/frame_overlap_counter.sv
// -----------------------------------------------------------------------------
// frame_overlap_counter
// Per-frame saturating overlap counter with first-hit position capture.
// Optional feature macro: COLLIDE_HITPOS_EN (builds the pending position regs;
// when undefined pend_x/pend_y are constant 0 and no registers exist).
// Ports:
//   clk, rst          : pixel clock, asynchronous active-low reset
//   clear             : drop the running count (monitor not counting)
//   restart           : frame boundary; count restarts with this pixel
//   count_en          : count overlaps on this cycle
//   overlap           : current pixel is a dino/obstacle overlap
//   vga_x, vga_y      : current pixel position
//   count             : running overlap count of the current frame
//   pend_x, pend_y    : position of the first overlap of the current frame
// -----------------------------------------------------------------------------
module frame_overlap_counter
    import trex_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               restart,
    input  logic               count_en,
    input  logic               overlap,
    input  logic [COORD_W-1:0] vga_x,
    input  logic [COORD_W-1:0] vga_y,
    output logic [CNT_W-1:0]   count,
    output logic [COORD_W-1:0] pend_x,
    output logic [COORD_W-1:0] pend_y
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;
    logic             first_s;

    // First overlap of a frame: the boundary pixel itself, or any overlap
    // while the count is still zero (a saturated count never returns to zero).
    always_comb begin
        first_s = 1'b0;
        if (clear) begin
            first_s = 1'b0;
        end else if (restart) begin
            first_s = overlap;
        end else if (count_en) begin
            first_s = overlap & (count_r == CNT_ZERO);
        end else begin
            first_s = 1'b0;
        end
    end

    // Running overlap count: restart at frame boundary, saturate at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= CNT_ZERO;
        end else if (clear) begin
            count_r <= CNT_ZERO;
        end else if (restart) begin
            count_r <= overlap ? CNT_ONE : CNT_ZERO;
        end else if (count_en && overlap && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

`ifdef COLLIDE_HITPOS_EN
    logic [COORD_W-1:0] pend_x_r;
    logic [COORD_W-1:0] pend_y_r;

    // Pending hit position: latched on the first overlap of each frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_x_r <= {COORD_W{1'b0}};
            pend_y_r <= {COORD_W{1'b0}};
        end else if (first_s) begin
            pend_x_r <= vga_x;
            pend_y_r <= vga_y;
        end else begin
            pend_x_r <= pend_x_r;
            pend_y_r <= pend_y_r;
        end
    end

    assign pend_x = pend_x_r;
    assign pend_y = pend_y_r;
`else
    logic unused_pos_s;
    assign unused_pos_s = ^{vga_x, vga_y, first_s};
    assign pend_x       = {COORD_W{1'b0}};
    assign pend_y       = {COORD_W{1'b0}};
`endif

endmodule

// File: rtl/collision_monitor.sv
// -----------------------------------------------------------------------------
// collision_monitor
// Pixel-stream dino/obstacle collision detector. Counts overlapping pixels per
// frame, confirms a hit after FRAME_CONFIRM consecutive hit frames and issues a
// one-cycle registered collide pulse.
// Optional feature macro: COLLIDE_HITPOS_EN (hit_x/hit_y capture; when
// undefined hit_x/hit_y are constant 0).
// Ports:
//   clk, rst               : 25 MHz pixel clock, asynchronous active-low reset
//   pix_valid              : pixel is in the visible area
//   frame_start            : first pixel of a frame
//   vga_x, vga_y           : current pixel position
//   dino_pix, obstacle_pix : sprite coverage of the current pixel
//   game_state             : 00 INIT, 01 PLAY, 10 DEAD
//   collide                : one-cycle confirmed collision pulse
//   overlap_count          : overlap total of the last evaluated frame
//   hit_x, hit_y           : first overlap position of the confirming frame
// -----------------------------------------------------------------------------
module collision_monitor
    import trex_pkg::*;
#(
    parameter int OVERLAP_MIN   = 4,
    parameter int FRAME_CONFIRM = 2,
    parameter int CNT_W         = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] vga_x,
    input  logic [COORD_W-1:0] vga_y,
    input  logic               dino_pix,
    input  logic               obstacle_pix,
    input  logic [1:0]         game_state,
    output logic               collide,
    output logic [CNT_W-1:0]   overlap_count,
    output logic [COORD_W-1:0] hit_x,
    output logic [COORD_W-1:0] hit_y
);

    localparam logic [3:0]       CONFIRM_C = 4'(FRAME_CONFIRM);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(OVERLAP_MIN);

    cm_state_e          state_r;
    logic [3:0]         hit_frames_r;
    logic               collide_r;
    logic [CNT_W-1:0]   overlap_count_r;

    logic               play_s;
    logic               overlap_s;
    logic               keep_s;
    logic               qual_s;
    logic [3:0]         hf_next_s;
    logic               confirm_s;
    logic [CNT_W-1:0]   count_s;
    logic [COORD_W-1:0] pend_x_s;
    logic [COORD_W-1:0] pend_y_s;

    assign play_s    = (game_state == GS_PLAY);
    assign overlap_s = pix_valid & dino_pix & obstacle_pix;

    // Counting runs while armed, and also on the arming frame_start pixel,
    // since that pixel already belongs to the first counted frame.
    assign keep_s = play_s & ((state_r == CM_ARMED) |
                              ((state_r == CM_IDLE) & frame_start));

    // Frame qualification and next hit-frame streak; a confirm needs an
    // evaluation while staying in PLAY (leaving PLAY wins over confirming).
    always_comb begin
        qual_s    = (count_s >= MIN_C);
        hf_next_s = 4'd0;
        if (qual_s) begin
            if (hit_frames_r >= CONFIRM_C) begin
                hf_next_s = CONFIRM_C;
            end else begin
                hf_next_s = hit_frames_r + 4'd1;
            end
        end else begin
            hf_next_s = 4'd0;
        end
        confirm_s = (state_r == CM_ARMED) & play_s & frame_start &
                    (hf_next_s == CONFIRM_C);
    end

    frame_overlap_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (~keep_s),
        .restart  (keep_s & frame_start),
        .count_en (keep_s),
        .overlap  (overlap_s),
        .vga_x    (vga_x),
        .vga_y    (vga_y),
        .count    (count_s),
        .pend_x   (pend_x_s),
        .pend_y   (pend_y_s)
    );

    // Monitor FSM with registered collide pulse and frame evaluation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= CM_IDLE;
            hit_frames_r    <= 4'd0;
            collide_r       <= 1'b0;
            overlap_count_r <= {CNT_W{1'b0}};
        end else begin
            collide_r <= 1'b0;
            case (state_r)
                CM_IDLE: begin
                    hit_frames_r <= 4'd0;
                    if (play_s && frame_start) begin
                        state_r <= CM_ARMED;
                    end else begin
                        state_r <= CM_IDLE;
                    end
                end
                CM_ARMED: begin
                    if (!play_s) begin
                        state_r      <= CM_IDLE;
                        hit_frames_r <= 4'd0;
                    end else if (frame_start) begin
                        overlap_count_r <= count_s;
                        hit_frames_r    <= hf_next_s;
                        if (confirm_s) begin
                            state_r   <= CM_FIRED;
                            collide_r <= 1'b1;
                        end else begin
                            state_r <= CM_ARMED;
                        end
                    end else begin
                        state_r <= CM_ARMED;
                    end
                end
                CM_FIRED: begin
                    if (!play_s) begin
                        state_r      <= CM_IDLE;
                        hit_frames_r <= 4'd0;
                    end else begin
                        state_r <= CM_FIRED;
                    end
                end
                default: begin
                    state_r      <= CM_IDLE;
                    hit_frames_r <= 4'd0;
                end
            endcase
        end
    end

    assign collide       = collide_r;
    assign overlap_count = overlap_count_r;

`ifdef COLLIDE_HITPOS_EN
    logic [COORD_W-1:0] hit_x_r;
    logic [COORD_W-1:0] hit_y_r;

    // Reported hit position: taken from the pending capture on confirmation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_x_r <= {COORD_W{1'b0}};
            hit_y_r <= {COORD_W{1'b0}};
        end else if (confirm_s) begin
            hit_x_r <= pend_x_s;
            hit_y_r <= pend_y_s;
        end else begin
            hit_x_r <= hit_x_r;
            hit_y_r <= hit_y_r;
        end
    end

    assign hit_x = hit_x_r;
    assign hit_y = hit_y_r;
`else
    logic unused_pend_s;
    assign unused_pend_s = ^{pend_x_s, pend_y_s};
    assign hit_x         = {COORD_W{1'b0}};
    assign hit_y         = {COORD_W{1'b0}};
`endif

endmodule
